// File: rtl/player_pkg.sv
// player_pkg: shared types and default constants for the player movement engine.
package player_pkg;
  localparam int POS_W = 10;
  localparam int X_MIN = 4;
  localparam int X_MAX = 639;
  localparam logic [7:0] KEY_LEFT   = 8'h04;
  localparam logic [7:0] KEY_RIGHT  = 8'h07;
  localparam logic [7:0] KEY_CROUCH = 8'h16;
  localparam logic [7:0] KEY_JUMP   = 8'h1A;
  typedef enum logic [1:0] {STAND = 2'd0, CROUCH = 2'd1, RISE = 2'd2, FALL = 2'd3} mstate_t;
endpackage

// File: rtl/player_motion_ctrl_key_match.sv
// key_match: reports whether a key code is present in any keycode slot; 8'h00 marks an empty slot.
module key_match #(
  parameter int NUM_KEYS = 4
) (
  input  logic [NUM_KEYS*8-1:0] keycodes_i,
  input  logic [7:0]            key_i,
  output logic                  held_o
);
  always_comb begin
    held_o = 1'b0;
    for (int k = 0; k < NUM_KEYS; k++) held_o = held_o | (key_i != 8'h00 && keycodes_i[8*k +: 8] == key_i);
  end
endmodule

// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl: per-player walk/jump/crouch engine with gravity, screen clamp and opponent blocking.
module player_motion_ctrl #(
  parameter int         NUM_KEYS   = 4,
  parameter int         POS_W      = player_pkg::POS_W,
  parameter int         X_INIT     = 40,
  parameter int         Y_GROUND   = 220,
  parameter int         WIDTH      = 120,
  parameter int         HEIGHT     = 180,
  parameter int         OPP_WIDTH  = 140,
  parameter int         OPP_HEIGHT = 240,
  parameter int         X_MIN      = player_pkg::X_MIN,
  parameter int         X_MAX      = player_pkg::X_MAX,
  parameter int         WALK_STEP  = 2,
  parameter int         JUMP_V0    = 12,
  parameter int         GRAVITY    = 1,
  parameter logic [7:0] KEY_LEFT   = player_pkg::KEY_LEFT,
  parameter logic [7:0] KEY_RIGHT  = player_pkg::KEY_RIGHT,
  parameter logic [7:0] KEY_CROUCH = player_pkg::KEY_CROUCH,
  parameter logic [7:0] KEY_JUMP   = player_pkg::KEY_JUMP
) (
  input  logic                  frame_clk,
  input  logic                  Reset,
  input  logic                  enable,
  input  logic [NUM_KEYS*8-1:0] keycodes,
  input  logic [POS_W-1:0]      opp_x,
  input  logic [POS_W-1:0]      opp_y,
  output logic [POS_W-1:0]      pos_x,
  output logic [POS_W-1:0]      pos_y,
  output logic [1:0]            mstate,
  output logic                  facing_right,
  output logic                  airborne
);
  import player_pkg::*;
  localparam int CW = POS_W + 2;
  typedef logic signed [CW-1:0] sw_t;
  localparam sw_t LO   = sw_t'(X_MIN);
  localparam sw_t HI   = sw_t'(X_MAX - WIDTH);
  localparam sw_t W_S  = sw_t'(WIDTH);
  localparam sw_t H_S  = sw_t'(HEIGHT);
  localparam sw_t OW_S = sw_t'(OPP_WIDTH);
  localparam sw_t OH_S = sw_t'(OPP_HEIGHT);
  localparam sw_t V0_S = sw_t'(JUMP_V0);
  localparam sw_t G_S  = sw_t'(GRAVITY);
  localparam sw_t ST_S = sw_t'(WALK_STEP);
  localparam sw_t YG_S = sw_t'(Y_GROUND);

  logic left, right, crouch, jump;
  key_match #(.NUM_KEYS(NUM_KEYS)) u_left   (.keycodes_i(keycodes), .key_i(KEY_LEFT),   .held_o(left));
  key_match #(.NUM_KEYS(NUM_KEYS)) u_right  (.keycodes_i(keycodes), .key_i(KEY_RIGHT),  .held_o(right));
  key_match #(.NUM_KEYS(NUM_KEYS)) u_crouch (.keycodes_i(keycodes), .key_i(KEY_CROUCH), .held_o(crouch));
  key_match #(.NUM_KEYS(NUM_KEYS)) u_jump   (.keycodes_i(keycodes), .key_i(KEY_JUMP),   .held_o(jump));

  mstate_t          state_q, state_d;
  logic [POS_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  sw_t              vy_q, vy_d, vx_q, vx_d;
  logic             face_q, face_d, armed_q, armed_d;

  logic air, v_ovl, blk_r, blk_l;
  sw_t  px, py, ox, oy, vx_key, vx, cand0, cand1, cand, vy_dec, vy_inc, y_up, y_dn;

  assign air    = state_q == RISE || state_q == FALL;
  assign px     = sw_t'({2'b00, pos_x_q});
  assign py     = sw_t'({2'b00, pos_y_q});
  assign ox     = sw_t'({2'b00, opp_x});
  assign oy     = sw_t'({2'b00, opp_y});
  assign vx_key = (right && !left) ? ST_S : (left && !right) ? -ST_S : '0;
  assign vx     = air ? vx_q : state_q == CROUCH ? '0 : vx_key;

  // Opponent blocking only stops a player that starts clear of the opponent, so overlapping boxes can separate.
  assign cand0  = px + vx;
  assign v_ovl  = py < oy + OH_S && oy < py + H_S;
  assign blk_r  = v_ovl && vx > 0 && px + W_S <= ox && cand0 + W_S > ox;
  assign blk_l  = v_ovl && vx < 0 && px >= ox + OW_S && cand0 < ox + OW_S;
  assign cand1  = blk_r ? ox - W_S : blk_l ? ox + OW_S : cand0;
  assign cand   = cand1 < LO ? LO : cand1 > HI ? HI : cand1;
  assign pos_x_d = POS_W'(cand);
  assign face_d  = air ? face_q : px < ox ? 1'b1 : px > ox ? 1'b0 : face_q;

  assign vy_dec = vy_q - G_S;
  assign vy_inc = vy_q + G_S > V0_S ? V0_S : vy_q + G_S;
  assign y_up   = py - vy_q;
  assign y_dn   = py + vy_inc;

  always_comb begin
    state_d = state_q;
    pos_y_d = pos_y_q;
    vy_d    = vy_q;
    vx_d    = vx_q;
    armed_d = armed_q | ~jump;
    case (state_q)
      STAND:
        if (jump && armed_q && !crouch) begin
          state_d = RISE;
          vy_d    = V0_S;
          vx_d    = vx_key;
          armed_d = 1'b0;
        end else if (crouch) state_d = CROUCH;
      CROUCH: if (!crouch) state_d = STAND;
      RISE: begin
        pos_y_d = y_up < 0 ? '0 : POS_W'(y_up);
        vy_d    = vy_dec > 0 ? vy_dec : '0;
        if (vy_dec <= 0) state_d = FALL;
      end
      FALL:
        if (y_dn >= YG_S) begin
          pos_y_d = POS_W'(Y_GROUND);
          vy_d    = '0;
          state_d = crouch ? CROUCH : STAND;
        end else begin
          pos_y_d = POS_W'(y_dn);
          vy_d    = vy_inc;
        end
    endcase
  end

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= STAND;
      pos_x_q <= POS_W'(X_INIT);
      pos_y_q <= POS_W'(Y_GROUND);
      vy_q    <= '0;
      vx_q    <= '0;
      face_q  <= 1'b1;
      armed_q <= 1'b1;
    end else if (enable) begin
      state_q <= state_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      vy_q    <= vy_d;
      vx_q    <= vx_d;
      face_q  <= face_d;
      armed_q <= armed_d;
    end
  end

  assign pos_x        = pos_x_q;
  assign pos_y        = pos_y_q;
  assign mstate       = state_q;
  assign facing_right = face_q;
  assign airborne     = air;
endmodule

// File: tb/tb_player_motion_ctrl.sv
// tb_player_motion_ctrl: directed and random frames compared against an integer model of the movement rules.
module tb_player_motion_ctrl;
  logic        frame_clk = 1'b0;
  logic        Reset = 1'b1;
  logic        enable = 1'b1;
  logic [31:0] keycodes = '0;
  logic [9:0]  opp_x = 10'd1000;
  logic [9:0]  opp_y = 10'd900;
  logic [9:0]  pos_x, pos_y;
  logic [1:0]  mstate;
  logic        facing_right, airborne;

  player_motion_ctrl dut (
    .frame_clk(frame_clk), .Reset(Reset), .enable(enable), .keycodes(keycodes),
    .opp_x(opp_x), .opp_y(opp_y), .pos_x(pos_x), .pos_y(pos_y), .mstate(mstate),
    .facing_right(facing_right), .airborne(airborne)
  );

  always #5 frame_clk = ~frame_clk;

  int errors = 0, checks = 0;
  int m_x, m_y, m_st, m_vy, m_vx, m_face, m_armed;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit held(input logic [7:0] c);
    for (int k = 0; k < 4; k++) if (c != 8'h00 && keycodes[8*k +: 8] == c) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_x = 40; m_y = 220; m_st = 0; m_vy = 0; m_vx = 0; m_face = 1; m_armed = 1;
  endtask

  // States: 0 stand, 1 crouch, 2 rise, 3 fall.
  task automatic model_step();
    bit l, r, c, j, air, ovl;
    int vx, nx, ny, nst, nvy, ox, oy;
    if (!enable) return;
    l = held(8'h04); r = held(8'h07); c = held(8'h16); j = held(8'h1A);
    ox = int'(opp_x); oy = int'(opp_y);
    air = m_st >= 2;
    vx = air ? m_vx : m_st == 1 ? 0 : (r && !l) ? 2 : (l && !r) ? -2 : 0;
    nx = m_x + vx;
    ovl = (m_y < oy + 240) && (oy < m_y + 180);
    if (ovl && vx > 0 && m_x + 120 <= ox && nx + 120 > ox) nx = ox - 120;
    if (ovl && vx < 0 && m_x >= ox + 140 && nx < ox + 140) nx = ox + 140;
    if (nx < 4) nx = 4;
    if (nx > 519) nx = 519;
    if (!air && ox > m_x) m_face = 1;
    if (!air && ox < m_x) m_face = 0;
    ny = m_y; nst = m_st; nvy = m_vy;
    if (m_st == 0) begin
      if (j && m_armed && !c) begin nst = 2; nvy = 12; m_vx = vx; m_armed = 0; end
      else if (c) nst = 1;
    end else if (m_st == 1) begin
      if (!c) nst = 0;
    end else if (m_st == 2) begin
      ny = m_y - m_vy < 0 ? 0 : m_y - m_vy;
      nvy = m_vy - 1 < 0 ? 0 : m_vy - 1;
      if (nvy == 0) nst = 3;
    end else begin
      nvy = m_vy + 1 > 12 ? 12 : m_vy + 1;
      if (m_y + nvy >= 220) begin ny = 220; nvy = 0; nst = c ? 1 : 0; end
      else ny = m_y + nvy;
    end
    if (!j) m_armed = 1;
    m_x = nx; m_y = ny; m_st = nst; m_vy = nvy;
  endtask

  task automatic compare_all();
    check("pos_x", pos_x, m_x);
    check("pos_y", pos_y, m_y);
    check("mstate", mstate, m_st);
    check("facing", facing_right, m_face);
    check("airborne", airborne, m_st >= 2);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      model_step();
      @(posedge frame_clk);
      #1;
      compare_all();
    end
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 5))
      0: return 8'h00;
      1: return 8'h04;
      2: return 8'h07;
      3: return 8'h16;
      4: return 8'h1A;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    int rise, apex;
    model_reset();
    #2 Reset = 1'b0;
    #1 compare_all();
    repeat (2) @(posedge frame_clk);
    @(negedge frame_clk) Reset = 1'b1;
    step(10);
    check("idle_x", pos_x, 40);
    check("idle_y", pos_y, 220);
    check("idle_state", mstate, 0);
    check("idle_face", facing_right, 1);

    keycodes = 32'h0007_0000;
    step(5);
    check("walk_x", pos_x, 50);
    keycodes = 32'h0007_0004;
    step(3);
    check("both_keys_x", pos_x, 50);

    keycodes = 32'h0000_001A;
    rise = 0; apex = 1000;
    repeat (40) begin
      step(1);
      if (mstate == 2'd2) rise++;
      if (int'(pos_y) < apex) apex = int'(pos_y);
    end
    check("rise_frames", rise, 12);
    check("apex_y", apex, 142);
    check("landed_y", pos_y, 220);
    check("no_rejump", mstate, 0);
    keycodes = '0;
    step(1);
    keycodes = 32'h1A00_0000;
    step(1);
    check("rejump", mstate, 2);
    step(30);
    keycodes = '0;
    step(2);

    opp_x = 10'd637; opp_y = 10'd220;
    keycodes = 32'h0000_0007;
    step(240);
    check("opp_stop_odd", pos_x, 517);
    opp_x = 10'd1000; opp_y = 10'd900;
    step(3);
    check("right_bound", pos_x, 519);
    keycodes = 32'h0000_0400;
    step(257);
    check("left_walk", pos_x, 5);
    step(1);
    check("left_bound", pos_x, 4);

    keycodes = 32'h0000_0007;
    step(36);
    check("pre_block_x", pos_x, 76);
    opp_x = 10'd200; opp_y = 10'd160;
    step(5);
    check("block_x", pos_x, 80);
    opp_y = 10'd420;
    step(3);
    check("pass_x", pos_x, 86);
    opp_x = 10'd1000; opp_y = 10'd900;
    keycodes = '0;
    step(1);

    keycodes = 32'h0000_001A;
    step(6);
    check("mid_jump_y", pos_y, 170);
    check("mid_jump_state", mstate, 2);
    #2 Reset = 1'b0;
    model_reset();
    #1 compare_all();
    keycodes = '0;
    @(negedge frame_clk) Reset = 1'b1;
    step(2);

    keycodes = 32'h001A_0000;
    step(15);
    check("fall_state", mstate, 3);
    check("fall_y", pos_y, 145);
    enable = 1'b0;
    keycodes = '0;
    step(3);
    keycodes = 32'h001A_0000;
    step(2);
    check("frozen_y", pos_y, 145);
    enable = 1'b1;
    step(30);
    check("frozen_armed", mstate, 0);
    keycodes = '0;
    step(2);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) keycodes = {pick(), pick(), pick(), pick()};
      if ($urandom_range(0, 19) == 0) begin
        opp_x = 10'($urandom_range(0, 700));
        opp_y = 10'($urandom_range(0, 500));
      end
      enable = $urandom_range(0, 9) != 0;
      step(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/player_motion_ctrl.md
Name: player_motion_ctrl

Overview:
- Per-player movement engine for the fighting-game datapath; the top level instantiates one per player, cross-wiring each instance's position to the other's opponent inputs.
- Decodes the USB keycode slots against a parameterised key map and runs an integrated jump/crouch state machine with gravity.
- Clamps the player to the screen bounds in the same cycle as the move, and blocks walking through the opponent.
- Registered positions feed the sprite/renderer, updated once per frame_clk.

Parameters:
- NUM_KEYS, 4, number of 8-bit keycode slots scanned
- POS_W, 10, position width (pixels)
- X_INIT, 40, reset X (left edge)
- Y_GROUND, 220, floor Y (top edge when standing)
- WIDTH, 120, own hitbox width
- HEIGHT, 180, own hitbox height
- OPP_WIDTH, 140, opponent hitbox width
- OPP_HEIGHT, 240, opponent hitbox height
- X_MIN, 4, leftmost legal left edge
- X_MAX, 639, rightmost legal right edge
- WALK_STEP, 2, horizontal pixels/frame
- JUMP_V0, 12, initial upward speed; also the terminal fall speed
- GRAVITY, 1, speed change per frame
- KEY_LEFT / KEY_RIGHT / KEY_CROUCH / KEY_JUMP, 8'h04 / 8'h07 / 8'h16 / 8'h1A, key map

Ports:
- frame_clk, in, 1, frame-rate clock (vsync)
- Reset, in, 1, asynchronous, active-low reset
- enable, in, 1, 0 freezes all state (pause/round-over)
- keycodes, in, NUM_KEYS*8, slot k = bits [8k+7:8k]; 8'h00 = empty
- opp_x, in, POS_W, opponent left edge
- opp_y, in, POS_W, opponent top edge
- pos_x, out, POS_W, own left edge
- pos_y, out, POS_W, own top edge
- mstate, out, 2, 0=STAND 1=CROUCH 2=RISE 3=FALL
- facing_right, out, 1, 1 when opponent is to the right
- airborne, out, 1, mstate is RISE or FALL

Behaviour:
- Reset (async, Reset=0) values:
  - pos_x=X_INIT, pos_y=Y_GROUND, mstate=STAND, vy=0, vx=0, facing_right=1, jump_armed=1.
- Key decode (combinational):
  - A key is "held" if any slot equals its code; 8'h00 never matches.
  - Duplicate codes across slots count once.
- Registered outputs: a key change is visible on outputs after exactly 1 frame_clk edge.
- enable=0: every register holds; the key edge detector does not update.
- Horizontal velocity vx (signed):
  - LEFT only → -WALK_STEP; RIGHT only → +WALK_STEP; both or neither → 0.
  - CROUCH state forces vx=0.
  - While airborne, vx is the value latched at takeoff; keys are ignored.
- FSM, evaluated each enabled edge:
  - STAND:
    - JUMP held and jump_armed and CROUCH not held → RISE, vy=JUMP_V0, jump_armed=0.
    - Otherwise, CROUCH held → CROUCH.
  - CROUCH: CROUCH released → STAND. JUMP is ignored.
  - RISE:
    - pos_y -= vy, then vy -= GRAVITY.
    - When vy reaches 0 → FALL.
    - pos_y saturates at 0 (no wrap).
  - FALL:
    - vy += GRAVITY, capped at JUMP_V0.
    - If pos_y + vy >= Y_GROUND: pos_y=Y_GROUND, vy=0, → STAND (CROUCH if held). Landing never overshoots the floor.
    - Otherwise pos_y += vy.
- jump_armed: set whenever JUMP is not held. Holding JUMP gives exactly one jump.
- Horizontal update:
  - Compute cand = pos_x + vx in POS_W+2-bit signed arithmetic.
  - Clamp cand to [X_MIN, X_MAX-WIDTH] in the same cycle; no one-frame overshoot.
  - Opponent block applies only when vertical spans overlap, i.e. [pos_y, pos_y+HEIGHT) intersects [opp_y, opp_y+OPP_HEIGHT):
    - vx>0, pos_x+WIDTH <= opp_x, cand+WIDTH > opp_x → cand = opp_x-WIDTH.
    - vx<0, pos_x >= opp_x+OPP_WIDTH, cand < opp_x+OPP_WIDTH → cand = opp_x+OPP_WIDTH.
  - Bound clamp has priority over opponent block.
  - Already-overlapping boxes (e.g. landing on the opponent): no push; the player may walk out.
- facing_right:
  - Updated only in STAND/CROUCH: 1 if opp_x > pos_x, 0 if opp_x < pos_x, hold if equal.
  - Frozen while airborne.

Decomposition:
- Package player_pkg: mstate_t enum (STAND, CROUCH, RISE, FALL), default key-map constants, screen bound constants, POS_W.
- Sub-module key_match: parameterised by NUM_KEYS; keycode bus plus one key code → held. Instantiated four times.
- FSM, vertical physics and horizontal clamp stay in player_motion_ctrl.

Test Plan:
- Reset release, no keys, 10 frames → pos_x=40, pos_y=220, mstate=STAND, facing_right=1.
- KEY_RIGHT in slot 2 for 5 frames → pos_x=50; add KEY_LEFT in slot 0 → pos_x stays 50.
- KEY_JUMP held 40 frames from ground →
  - RISE for 12 frames, apex pos_y=142.
  - FALL, landing exactly at 220.
  - No second jump until JUMP is released and re-pressed.
- pos_x=517, KEY_RIGHT held → pos_x saturates at 519 (X_MAX-WIDTH) with no overshoot; LEFT from x=5 → 4.
- opp_x=200, opp_y=160, start pos_x=76, RIGHT held → pos_x stops at 80; opp_y=420 (no vertical overlap) → passes through.
- Mid-jump (pos_y=170, RISE) assert Reset=0 asynchronously → outputs return to reset values before the next edge; enable=0 mid-fall → pos_y frozen.
